// File: rtl/adc_capture_buffer.sv
// ---------------------------------------------------------------------------
// adc_capture_buffer
//
// Purpose:
//   Generates the CONVST/RD strobes of a parallel ADC at a selectable sample
//   period and latches each conversion result. Samples feed a triggered
//   capture buffer: once armed, a rising crossing of trigLevel starts a
//   frame of DEPTH samples, after which the buffer is frozen. The display
//   side reads the buffer by address at any time.
//
// Ports:
//   Clk         in   system clock
//   adcRst      in   asynchronous active-high reset
//   adcFr       in   rate select, period P = DIV_BASE << adcFr (taken at wrap)
//   D           in   ADC parallel data
//   trigLevel   in   unsigned trigger threshold
//   arm         in   one-cycle pulse, start a new capture
//   autoRearm   in   1 = re-arm automatically after each frame
//   rdAddr      in   display read address
//   CONVST      out  active-low convert start
//   RD          out  active-low read strobe
//   curveData   out  latest sample
//   sampleValid out  one-cycle pulse when curveData updates
//   rdData      out  buffer word at rdAddr (1-cycle latency, 0 out of range)
//   captureDone out  buffer frozen with a full frame
//   triggered   out  trigger seen, frame filling
//
// Optional feature macro: ADC_TRIG_TIMEOUT_EN
//   When defined, an armed capture that sees DEPTH samples without a trigger
//   forces a trigger on the DEPTH-th sample.
// ---------------------------------------------------------------------------
module adc_capture_buffer #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 640,
  parameter int ADDR_W      = 10,
  parameter int DIV_BASE    = 100,
  parameter int CONV_PULSE  = 2,
  parameter int CONV_CYCLES = 80,
  parameter int RD_CYCLES   = 4
) (
  input  logic              Clk,
  input  logic              adcRst,
  input  logic [2:0]        adcFr,
  input  logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] trigLevel,
  input  logic              arm,
  input  logic              autoRearm,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic              CONVST,
  output logic              RD,
  output logic [DATA_W-1:0] curveData,
  output logic              sampleValid,
  output logic [DATA_W-1:0] rdData,
  output logic              captureDone,
  output logic              triggered
);

  // Largest period is DIV_BASE << 7.
  localparam int CNT_W  = $clog2((DIV_BASE << 7) + 1);
  localparam int PH_W   = $clog2(CONV_PULSE + CONV_CYCLES + RD_CYCLES + 1);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [MEM_AW-1:0] LAST_ADDR = MEM_AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    C_IDLE  = 3'd0,
    C_CONV  = 3'd1,
    C_WAIT  = 3'd2,
    C_READ  = 3'd3,
    C_LATCH = 3'd4
  } conv_state_t;

  typedef enum logic [1:0] {
    IDLE_CAP = 2'd0,
    ARMED    = 2'd1,
    FILL     = 2'd2,
    DONE     = 2'd3
  } cap_state_t;

  // ------------------------------------------------------------------
  // Sample-period counter
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_last_s;
  logic [2:0]       fr_q, fr_d;
  logic             tick_s;

  // Next counter value; the rate select is only taken at the wrap so a
  // change never shortens or stretches the period already running.
  always_comb begin
    period_last_s = CNT_W'((DIV_BASE << fr_q) - 1);
    tick_s        = (cnt_q == period_last_s);
    if (tick_s) begin
      cnt_d = '0;
      fr_d  = adcFr;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      fr_d  = fr_q;
    end
  end

  // Period counter registers.
  always_ff @(posedge Clk or posedge adcRst) begin
    if (adcRst) begin
      cnt_q <= '0;
      fr_q  <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
      fr_q  <= fr_d;
    end
  end

  // ------------------------------------------------------------------
  // Conversion FSM: strobes and sample latch, all outputs registered
  // ------------------------------------------------------------------
  conv_state_t       conv_state_q;
  logic [PH_W-1:0]   ph_q;
  logic              convst_q;
  logic              rd_q;
  logic [DATA_W-1:0] curve_data_q;
  logic              sample_valid_q;

  // Conversion sequencer; a tick arriving outside IDLE is simply dropped.
  always_ff @(posedge Clk or posedge adcRst) begin
    if (adcRst) begin
      conv_state_q   <= C_IDLE;
      ph_q           <= '0;
      convst_q       <= 1'b1;
      rd_q           <= 1'b1;
      curve_data_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      case (conv_state_q)
        C_IDLE: begin
          if (tick_s) begin
            conv_state_q <= C_CONV;
            ph_q         <= '0;
            convst_q     <= 1'b0;
          end
        end
        C_CONV: begin
          if (ph_q == PH_W'(CONV_PULSE - 1)) begin
            conv_state_q <= C_WAIT;
            ph_q         <= '0;
            convst_q     <= 1'b1;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        C_WAIT: begin
          if (ph_q == PH_W'(CONV_CYCLES - 1)) begin
            conv_state_q <= C_READ;
            ph_q         <= '0;
            rd_q         <= 1'b0;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        C_READ: begin
          // D is taken on the edge that ends the last RD-low cycle.
          if (ph_q == PH_W'(RD_CYCLES - 1)) begin
            conv_state_q   <= C_LATCH;
            ph_q           <= '0;
            rd_q           <= 1'b1;
            curve_data_q   <= D;
            sample_valid_q <= 1'b1;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        C_LATCH: begin
          conv_state_q <= C_IDLE;
        end
        default: begin
          conv_state_q <= C_IDLE;
          ph_q         <= '0;
          convst_q     <= 1'b1;
          rd_q         <= 1'b1;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Capture FSM
  // ------------------------------------------------------------------
  cap_state_t        cap_state_q;
  logic [MEM_AW-1:0] wr_ptr_q;
  logic [DATA_W-1:0] prev_q;
  logic              prev_valid_q;
  logic              triggered_q;
  logic              capture_done_q;
  logic              trig_hit_s;
  logic              force_s;
  logic              trig_s;
  logic              we_s;
  logic [MEM_AW-1:0] waddr_s;
`ifdef ADC_TRIG_TIMEOUT_EN
  logic [MEM_AW-1:0] to_cnt_q;
`endif

  // Trigger decision: a rising crossing needs a valid previous sample, so
  // the first sample after arm can never trigger.
  always_comb begin
    trig_hit_s = sample_valid_q && prev_valid_q &&
                 (prev_q < trigLevel) && (curve_data_q >= trigLevel);
`ifdef ADC_TRIG_TIMEOUT_EN
    force_s = sample_valid_q && (to_cnt_q == LAST_ADDR);
`else
    force_s = 1'b0;
`endif
    trig_s = trig_hit_s | force_s;
  end

  // Buffer write decode; arm takes priority so an aborted frame writes nothing.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = '0;
    if (arm) begin
      we_s = 1'b0;
    end else begin
      case (cap_state_q)
        ARMED: begin
          if (trig_s) begin
            we_s    = 1'b1;
            waddr_s = '0;
          end else begin
            we_s = 1'b0;
          end
        end
        FILL: begin
          if (sample_valid_q) begin
            we_s    = 1'b1;
            waddr_s = wr_ptr_q;
          end else begin
            we_s = 1'b0;
          end
        end
        default: begin
          we_s = 1'b0;
        end
      endcase
    end
  end

  // Capture state, write pointer, trigger history and status levels.
  always_ff @(posedge Clk or posedge adcRst) begin
    if (adcRst) begin
      cap_state_q    <= IDLE_CAP;
      wr_ptr_q       <= '0;
      prev_q         <= '0;
      prev_valid_q   <= 1'b0;
      triggered_q    <= 1'b0;
      capture_done_q <= 1'b0;
`ifdef ADC_TRIG_TIMEOUT_EN
      to_cnt_q       <= '0;
`endif
    end else if (arm) begin
      cap_state_q    <= ARMED;
      prev_valid_q   <= 1'b0;
      triggered_q    <= 1'b0;
      capture_done_q <= 1'b0;
`ifdef ADC_TRIG_TIMEOUT_EN
      to_cnt_q       <= '0;
`endif
    end else begin
      if (sample_valid_q) begin
        prev_q       <= curve_data_q;
        prev_valid_q <= 1'b1;
      end
      case (cap_state_q)
        IDLE_CAP: begin
          cap_state_q <= IDLE_CAP;
        end
        ARMED: begin
          if (trig_s) begin
            cap_state_q    <= FILL;
            wr_ptr_q       <= MEM_AW'(1);
            triggered_q    <= 1'b1;
            // With auto re-arm the previous frame stays flagged until here.
            capture_done_q <= 1'b0;
`ifdef ADC_TRIG_TIMEOUT_EN
            to_cnt_q       <= '0;
          end else if (sample_valid_q) begin
            to_cnt_q <= to_cnt_q + MEM_AW'(1);
`endif
          end
        end
        FILL: begin
          if (sample_valid_q) begin
            wr_ptr_q <= wr_ptr_q + MEM_AW'(1);
            if (wr_ptr_q == LAST_ADDR) begin
              cap_state_q    <= DONE;
              triggered_q    <= 1'b0;
              capture_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (autoRearm) begin
            cap_state_q <= ARMED;
          end
        end
        default: begin
          cap_state_q    <= IDLE_CAP;
          triggered_q    <= 1'b0;
          capture_done_q <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Capture memory and display readout
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Buffer storage; contents deliberately survive reset.
  always_ff @(posedge Clk) begin
    if (we_s) begin
      mem_q[waddr_s] <= curve_data_q;
    end
  end

  // Read mux; addresses past the frame return zero.
  always_comb begin
    if ({1'b0, rdAddr} < DEPTH_X) begin
      rd_data_d = mem_q[rdAddr[MEM_AW-1:0]];
    end else begin
      rd_data_d = '0;
    end
  end

  // Registered read port; a same-cycle write is not forwarded (old word).
  always_ff @(posedge Clk or posedge adcRst) begin
    if (adcRst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign CONVST      = convst_q;
  assign RD          = rd_q;
  assign curveData   = curve_data_q;
  assign sampleValid = sample_valid_q;
  assign rdData      = rd_data_q;
  assign captureDone = capture_done_q;
  assign triggered   = triggered_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer. A 16-sample buffer keeps the
// capture frames short; strobe timing uses the default period parameters.
// Cycle index cyc = number of rising edges since adcRst was released.
module tb_adc_capture_buffer;

  localparam int DEPTH = 16;
`ifdef ADC_TRIG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       adcRst;
  logic [2:0] adcFr;
  logic [7:0] D;
  logic [7:0] trigLevel;
  logic       arm;
  logic       autoRearm;
  logic [9:0] rdAddr;
  logic       CONVST;
  logic       RD;
  logic [7:0] curveData;
  logic       sampleValid;
  logic [7:0] rdData;
  logic       captureDone;
  logic       triggered;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  adc_capture_buffer #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .adcRst(adcRst), .adcFr(adcFr), .D(D), .trigLevel(trigLevel),
    .arm(arm), .autoRearm(autoRearm), .rdAddr(rdAddr), .CONVST(CONVST),
    .RD(RD), .curveData(curveData), .sampleValid(sampleValid),
    .rdData(rdData), .captureDone(captureDone), .triggered(triggered)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      cyc++;
    end
    #1;
  endtask

  task automatic goto(input int t);
    step(t - cyc);
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  // Present v, wait (bounded) for its sampleValid, then one more edge so the
  // capture FSM has acted on it.
  task automatic sample(input logic [7:0] v);
    bit seen;
    seen = 1'b0;
    D = v;
    for (int i = 0; i < 1000 && !seen; i++) begin
      step(1);
      if (sampleValid === 1'b1) seen = 1'b1;
    end
    chk("sv_seen", seen, 1);
    chk("curve", curveData, v);
    step(1);
  endtask

  task automatic read_chk(input string tag, input int a, input logic [7:0] e);
    rdAddr = 10'(a);
    step(1);
    chk(tag, rdData, e);
  endtask

  initial begin
    int  sv_cnt;
    int  low_cnt;
    bit  seen;

    adcRst = 1'b1; adcFr = 3'd0; D = 8'h5A; trigLevel = 8'h80;
    arm = 1'b0; autoRearm = 1'b0; rdAddr = 10'd0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_convst", CONVST, 1);
    chk("rst_rd", RD, 1);
    chk("rst_curve", curveData, 0);
    chk("rst_sv", sampleValid, 0);
    chk("rst_rddata", rdData, 0);
    chk("rst_done", captureDone, 0);
    chk("rst_trig", triggered, 0);
    @(posedge Clk); #2; adcRst = 1'b0; cyc = 0;

    // ---------------- strobe timing, adcFr=0 ----------------
    // tick at count 99, CONVST low on edges 100..101, WAIT 80, RD low 182..185
    goto(99);  chk("convst_pre", CONVST, 1);
    step(1);   chk("convst_fall", CONVST, 0);
    step(1);   chk("convst_low2", CONVST, 0);
    step(1);   chk("convst_rise", CONVST, 1);
    goto(181); chk("rd_pre", RD, 1);
    step(1);   chk("rd_fall", RD, 0);
    goto(185); chk("rd_last", RD, 0);
    chk("sv_early", sampleValid, 0);
    step(1);   chk("rd_rise", RD, 1);
    chk("sv_pulse", sampleValid, 1);
    chk("curve_5a", curveData, 8'h5A);
    step(1);   chk("sv_one", sampleValid, 0);
    goto(199); chk("convst_p2_pre", CONVST, 1);
    step(1);   chk("convst_p2_fall", CONVST, 0);

    // ---------------- rate change mid-period ----------------
    goto(250); adcFr = 3'd3;
    goto(299); chk("fr_cur_pre", CONVST, 1);
    step(1);   chk("fr_cur_fall", CONVST, 0);
    goto(1099); chk("fr_800_pre", CONVST, 1);
    step(1);   chk("fr_800_fall", CONVST, 0);
    goto(1500); adcFr = 3'd0;
    goto(1899); chk("fr_back_pre", CONVST, 1);
    step(1);   chk("fr_back_fall", CONVST, 0);
    goto(1999); chk("fr_100_pre", CONVST, 1);
    step(1);   chk("fr_100_fall", CONVST, 0);

    // ---------------- ramp capture ----------------
    trigLevel = 8'h80;
    arm_pulse();
    chk("arm_done", captureDone, 0);
    chk("arm_trig", triggered, 0);
    sample(8'h70); chk("ramp70_trig", triggered, 0);
    sample(8'h78); chk("ramp78_trig", triggered, 0);
    sample(8'h80); chk("ramp80_trig", triggered, 1);
    for (int k = 1; k < DEPTH - 1; k++) sample(8'(8'h80 + 8 * k));
    chk("ramp_fill_trig", triggered, 1);
    chk("ramp_fill_done", captureDone, 0);
    sample(8'hF8);
    chk("ramp_end_done", captureDone, 1);
    chk("ramp_end_trig", triggered, 0);
    read_chk("buf0", 0, 8'h80);
    read_chk("buf1", 1, 8'h88);
    read_chk("buf7", 7, 8'hB8);
    read_chk("buf15", 15, 8'hF8);
    sample(8'h00);
    sample(8'hFF);
    chk("frozen_done", captureDone, 1);
    read_chk("frozen0", 0, 8'h80);
    read_chk("frozen1", 1, 8'h88);

    // ---------------- no trigger on constant input ----------------
    arm_pulse();
    chk("const_arm_done", captureDone, 0);
    for (int k = 0; k < DEPTH - 1; k++) sample(8'hFF);
    chk("const_pre_trig", triggered, 0);
    sample(8'hFF);
    chk("const_nth_trig", triggered, TO_EN);
    for (int k = 0; k < 4; k++) sample(8'hFF);
    chk("const_trig", triggered, TO_EN);
    chk("const_done", captureDone, 0);
    read_chk("const_buf0", 0, TO_EN ? 8'hFF : 8'h80);

    // ---------------- auto re-arm, two frames ----------------
    autoRearm = 1'b1;
    arm_pulse();
    sample(8'h40);
    sample(8'h90);
    chk("f1_trig", triggered, 1);
    for (int k = 1; k < DEPTH; k++) sample(8'(8'h90 + k));
    chk("f1_done", captureDone, 1);
    chk("f1_trig_end", triggered, 0);
    sample(8'h95);
    sample(8'h20);
    chk("rearm_done", captureDone, 1);
    chk("rearm_trig", triggered, 0);
    read_chk("f1_buf0", 0, 8'h90);
    read_chk("f1_buf5", 5, 8'h95);
    sample(8'hA0);
    chk("f2_trig", triggered, 1);
    chk("f2_done_clr", captureDone, 0);
    read_chk("f2_buf0", 0, 8'hA0);
    for (int k = 1; k < 5; k++) sample(8'(8'hA0 + k));
    rdAddr = 10'd5;
    sample(8'hA5);
    chk("rw_old", rdData, 8'h95);
    step(1);
    chk("rw_new", rdData, 8'hA5);
    for (int k = 6; k < DEPTH; k++) sample(8'(8'hA0 + k));
    chk("f2_done", captureDone, 1);
    read_chk("f2_buf15", 15, 8'hAF);
    read_chk("oob_700", 700, 8'h00);
    read_chk("oob_depth", DEPTH, 8'h00);

    // ---------------- reset during READ ----------------
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step(1);
      if (RD === 1'b0) seen = 1'b1;
    end
    chk("rd_found", seen, 1);
    #2; adcRst = 1'b1;
    #1;
    chk("arst_rd", RD, 1);
    chk("arst_convst", CONVST, 1);
    chk("arst_sv", sampleValid, 0);
    chk("arst_done", captureDone, 0);
    chk("arst_curve", curveData, 0);
    @(posedge Clk); #2; adcRst = 1'b0; cyc = 0;
    sv_cnt = 0; low_cnt = 0;
    for (int i = 1; i < 100; i++) begin
      step(1);
      if (sampleValid !== 1'b0) sv_cnt++;
      if (CONVST !== 1'b1) low_cnt++;
    end
    chk("post_rst_sv", sv_cnt, 0);
    chk("post_rst_convst", low_cnt, 0);
    chk("post_rst_curve", curveData, 0);
    step(1);
    chk("post_rst_fall", CONVST, 0);
    sample(8'h10);
    sample(8'h90);
    chk("idle_no_trig", triggered, 0);
    chk("idle_no_done", captureDone, 0);
    read_chk("buf_kept", 0, 8'hA0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
